// File: rtl/spr_pkg.sv
// Shared definitions for the SPR address generator: widths, SPR indices,
// addressing-mode encodings, FSM states and small mode-decode helpers.
package spr_pkg;

    localparam int SPR_DATA_W = 16;
    localparam int SPR_ADDR_W = 4;
    localparam int SPR_STEP   = 2;

    typedef enum logic [3:0] {
        SPR_ZERO  = 4'd0,
        SPR_AR    = 4'd1,
        SPR_BR    = 4'd2,
        SPR_IR    = 4'd3,
        SPR_SP    = 4'd4,
        SPR_BP    = 4'd5,
        SPR_DR    = 4'd6,
        SPR_SPARE = 4'd7
    } spr_idx_t;

    typedef enum logic [2:0] {
        MODE_ABS         = 3'd0,
        MODE_AR          = 3'd1,
        MODE_BASE_IDX    = 3'd2,
        MODE_BP_REL      = 3'd3,
        MODE_PUSH        = 3'd4,
        MODE_POP         = 3'd5,
        MODE_IDX_POSTINC = 3'd6,
        MODE_RSVD        = 3'd7
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDA,
        S_RDB,
        S_CALC,
        S_WB,
        S_RESP
    } state_t;

    // Modes that resolve without touching the SPR file at all.
    function automatic logic mode_no_access(mode_t m);
        return (m == MODE_ABS) || (m == MODE_RSVD);
    endfunction

    function automatic logic mode_two_reg(mode_t m);
        return (m == MODE_BASE_IDX) || (m == MODE_IDX_POSTINC);
    endfunction

    function automatic logic mode_writes(mode_t m);
        return (m == MODE_PUSH) || (m == MODE_POP) || (m == MODE_IDX_POSTINC);
    endfunction

    function automatic spr_idx_t first_index(mode_t m);
        case (m)
            MODE_AR:                      return SPR_AR;
            MODE_BASE_IDX,
            MODE_IDX_POSTINC:             return SPR_BR;
            MODE_BP_REL:                  return SPR_BP;
            MODE_PUSH, MODE_POP:          return SPR_SP;
            default:                      return SPR_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/spr_agu_calc.sv
// Combinational effective-address adder: op_a + op_b + disp/step, plus the
// updated SP/IR value that gets written back for stack and post-increment modes.
module spr_agu_calc
    import spr_pkg::*;
#(
    parameter int DATA_W = SPR_DATA_W,
    parameter int STEP   = SPR_STEP
) (
    input  mode_t             mode,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] disp,
    output logic [DATA_W-1:0] ea,
    output logic [DATA_W-1:0] new_val
);

    logic [DATA_W-1:0] step;
    logic [DATA_W-1:0] add_b;
    logic [DATA_W-1:0] add_d;
    logic [DATA_W-1:0] sum;

    assign step = DATA_W'(STEP);

    // PUSH pre-decrements so its address and its new SP are the same sum.
    always_comb begin
        add_b   = '0;
        add_d   = '0;
        new_val = '0;
        case (mode)
            MODE_ABS, MODE_AR, MODE_BP_REL: add_d = disp;
            MODE_BASE_IDX: begin
                add_b = op_b;
                add_d = disp;
            end
            MODE_PUSH:        add_d = -step;
            MODE_IDX_POSTINC: add_b = op_b;
            default:          add_d = '0;
        endcase
        sum = op_a + add_b + add_d;
        ea  = sum;
        case (mode)
            MODE_PUSH:        new_val = sum;
            MODE_POP:         new_val = op_a + step;
            MODE_IDX_POSTINC: new_val = op_b + step;
            default:          new_val = '0;
        endcase
    end

endmodule

// File: rtl/spr_address_generator.sv
// SPR-port initiator: reads base/index registers, forms a 16-bit effective
// address and writes back SP/IR for stack and post-increment modes.
module spr_address_generator
    import spr_pkg::*;
#(
    parameter int DATA_W = SPR_DATA_W,
    parameter int ADDR_W = SPR_ADDR_W,
    parameter int STEP   = SPR_STEP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_mode,
    input  logic [DATA_W-1:0] req_disp,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_ea,
    output logic              resp_err,
    output logic              spr_rd_en,
    output logic [ADDR_W-1:0] spr_rd_addr,
    input  logic [DATA_W-1:0] spr_rd_data,
    output logic              spr_wr_en,
    output logic [ADDR_W-1:0] spr_wr_addr,
    output logic [DATA_W-1:0] spr_wr_data
);

    state_t            state, state_next;
    mode_t             mode_q, req_mode_e;
    logic [DATA_W-1:0] disp_q, op_a_q, op_b, ea_q, new_q;
    logic              err_q;
    logic [DATA_W-1:0] calc_ea, calc_new;

    assign req_mode_e = mode_t'(req_mode);

    // Second operand only exists for the two-register modes; mask stale read data otherwise.
    assign op_b = mode_two_reg(mode_q) ? spr_rd_data : '0;

    spr_agu_calc #(
        .DATA_W (DATA_W),
        .STEP   (STEP)
    ) u_calc (
        .mode    (mode_q),
        .op_a    (op_a_q),
        .op_b    (op_b),
        .disp    (disp_q),
        .ea      (calc_ea),
        .new_val (calc_new)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_ea     = '0;
        resp_err    = 1'b0;
        spr_rd_en   = 1'b0;
        spr_rd_addr = '0;
        spr_wr_en   = 1'b0;
        spr_wr_addr = '0;
        spr_wr_data = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_next = mode_no_access(req_mode_e) ? S_RESP : S_RDA;
            end
            S_RDA: begin
                spr_rd_en   = 1'b1;
                spr_rd_addr = ADDR_W'(first_index(mode_q));
                state_next  = S_RDB;
            end
            S_RDB: begin
                if (mode_two_reg(mode_q)) begin
                    spr_rd_en   = 1'b1;
                    spr_rd_addr = ADDR_W'(SPR_IR);
                end
                state_next = S_CALC;
            end
            S_CALC: begin
                state_next = mode_writes(mode_q) ? S_WB : S_RESP;
            end
            S_WB: begin
                spr_wr_en   = 1'b1;
                spr_wr_addr = (mode_q == MODE_IDX_POSTINC) ? ADDR_W'(SPR_IR) : ADDR_W'(SPR_SP);
                spr_wr_data = new_q;
                state_next  = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_ea    = ea_q;
                resp_err   = err_q;
                if (resp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ABS and reserved results are known at accept time, so they bypass the read pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_ABS;
            disp_q <= '0;
            op_a_q <= '0;
            ea_q   <= '0;
            new_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        mode_q <= req_mode_e;
                        disp_q <= req_disp;
                        ea_q   <= (req_mode_e == MODE_ABS) ? req_disp : '0;
                        err_q  <= (req_mode_e == MODE_RSVD);
                    end
                end
                S_RDB:  op_a_q <= spr_rd_data;
                S_CALC: begin
                    ea_q  <= calc_ea;
                    new_q <= calc_new;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spr_address_generator.sv
// Directed bench for spr_address_generator: a vector table over all modes plus
// hand sequences for reset, response back-pressure and reset during CALC.
module tb_spr_address_generator;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_mode;
    logic [15:0] req_disp;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_ea;
    logic        resp_err;
    logic        spr_rd_en;
    logic [3:0]  spr_rd_addr;
    logic [15:0] spr_rd_data;
    logic        spr_wr_en;
    logic [3:0]  spr_wr_addr;
    logic [15:0] spr_wr_data;

    spr_address_generator dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_mode    (req_mode),
        .req_disp    (req_disp),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_ea     (resp_ea),
        .resp_err    (resp_err),
        .spr_rd_en   (spr_rd_en),
        .spr_rd_addr (spr_rd_addr),
        .spr_rd_data (spr_rd_data),
        .spr_wr_en   (spr_wr_en),
        .spr_wr_addr (spr_wr_addr),
        .spr_wr_data (spr_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int c0 = 0;
    int rd_base = 0;
    int wr_base = 0;

    logic [15:0] regs [8];
    logic [3:0]  rd_log [$];
    int          wr_count = 0;
    int          wr_cyc = 0;
    int          bad_strobe = 0;
    logic [3:0]  last_wr_addr = '0;
    logic [15:0] last_wr_data = '0;

    typedef struct {
        logic [2:0]  mode;
        logic [15:0] disp;
        logic [15:0] ar, br, ir, sp, bp;
        logic [15:0] exp_ea;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        logic [3:0]  exp_rd_a;
        int          exp_wr;
        logic [3:0]  exp_wr_addr;
        logic [15:0] exp_wr_data;
    } vec_t;

    vec_t vecs [10];

    always @(posedge clk) cyc <= cyc + 1;

    // SPR file model: one-cycle read latency, contents owned by the stimulus process.
    always @(posedge clk) begin
        if (spr_rd_en) spr_rd_data <= regs[spr_rd_addr[2:0]];
    end

    always @(negedge clk) begin
        if (spr_rd_en) rd_log.push_back(spr_rd_addr);
        if (spr_wr_en) begin
            wr_count++;
            wr_cyc       = cyc;
            last_wr_addr = spr_wr_addr;
            last_wr_data = spr_wr_data;
        end
        if (spr_rd_en && spr_wr_en) bad_strobe++;
        if (spr_wr_en && spr_wr_addr == 4'd0) bad_strobe++;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] get_rd(input int idx);
        if (idx < rd_log.size()) return rd_log[idx];
        return 4'hF;
    endfunction

    // Called at a negedge with the DUT idle; returns cycles from accept to resp_valid (-1 on timeout).
    task automatic apply_stimulus(input logic [2:0] mode, input logic [15:0] disp, output int lat);
        req_mode  = mode;
        req_disp  = disp;
        req_valid = 1'b1;
        c0        = cyc;
        rd_base   = rd_log.size();
        wr_base   = wr_count;
        @(posedge clk);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid) begin
                lat = cyc - c0;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        string tag;

        //            mode  disp     ar       br       ir       sp       bp       ea       err  lat rd a     wr wa    wd
        vecs[0] = '{3'd0, 16'h1234, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h1234, 1'b0, 1, 0, 4'd0, 0, 4'd0, 16'h0000};
        vecs[1] = '{3'd1, 16'hFFFE, 16'h0100, 16'h3000, 16'h0040, 16'h5000, 16'h6000, 16'h00FE, 1'b0, 4, 1, 4'd1, 0, 4'd0, 16'h0000};
        vecs[2] = '{3'd2, 16'h0004, 16'h0111, 16'h1000, 16'h0020, 16'h0777, 16'h0999, 16'h1024, 1'b0, 4, 2, 4'd2, 0, 4'd0, 16'h0000};
        vecs[3] = '{3'd3, 16'h0020, 16'h0111, 16'h0222, 16'h0333, 16'h0444, 16'hFFF0, 16'h0010, 1'b0, 4, 1, 4'd5, 0, 4'd0, 16'h0000};
        vecs[4] = '{3'd4, 16'h0000, 16'h0111, 16'h0222, 16'h0333, 16'h0000, 16'h0555, 16'hFFFE, 1'b0, 5, 1, 4'd4, 1, 4'd4, 16'hFFFE};
        vecs[5] = '{3'd5, 16'h0000, 16'h0111, 16'h0222, 16'h0333, 16'h0200, 16'h0555, 16'h0200, 1'b0, 5, 1, 4'd4, 1, 4'd4, 16'h0202};
        vecs[6] = '{3'd6, 16'h5555, 16'h0111, 16'h2000, 16'h0006, 16'h0444, 16'h0555, 16'h2006, 1'b0, 5, 2, 4'd2, 1, 4'd3, 16'h0008};
        vecs[7] = '{3'd7, 16'h1234, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h0000, 1'b1, 1, 0, 4'd0, 0, 4'd0, 16'h0000};
        vecs[8] = '{3'd6, 16'h0000, 16'h0111, 16'h0001, 16'hFFFF, 16'h0444, 16'h0555, 16'h0000, 1'b0, 5, 2, 4'd2, 1, 4'd3, 16'h0001};
        vecs[9] = '{3'd4, 16'h1234, 16'h0111, 16'h0222, 16'h0333, 16'h8000, 16'h0555, 16'h7FFE, 1'b0, 5, 1, 4'd4, 1, 4'd4, 16'h7FFE};

        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
        regs[6]    = 16'h7777;
        reset      = 1'b1;
        req_valid  = 1'b1;
        req_mode   = 3'd2;
        req_disp   = 16'h00AA;
        resp_ready = 1'b1;

        // Reset held with a live request: idle, ready, nothing strobed.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check_output("reset_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check_output("reset_resp_ea", {16'd0, resp_ea}, 32'd0);
        check_output("reset_strobes", {30'd0, spr_rd_en, spr_wr_en}, 32'd0);
        check_output("reset_addrs", {24'd0, spr_rd_addr, spr_wr_addr}, 32'd0);
        check_output("reset_wr_data", {16'd0, spr_wr_data}, 32'd0);
        check_output("reset_no_reads", rd_log.size(), 32'd0);
        req_valid = 1'b0;
        reset     = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            regs[1] = vecs[v].ar;
            regs[2] = vecs[v].br;
            regs[3] = vecs[v].ir;
            regs[4] = vecs[v].sp;
            regs[5] = vecs[v].bp;
            apply_stimulus(vecs[v].mode, vecs[v].disp, lat);
            tag = $sformatf("v%0d_", v);
            check_output({tag, "latency"}, lat, vecs[v].exp_lat);
            check_output({tag, "resp_ea"}, {16'd0, resp_ea}, {16'd0, vecs[v].exp_ea});
            check_output({tag, "resp_err"}, {31'd0, resp_err}, {31'd0, vecs[v].exp_err});
            check_output({tag, "ready_in_resp"}, {31'd0, req_ready}, 32'd0);
            check_output({tag, "rd_count"}, rd_log.size() - rd_base, vecs[v].exp_rd);
            if (vecs[v].exp_rd > 0)
                check_output({tag, "rd_addr_a"}, {28'd0, get_rd(rd_base)}, {28'd0, vecs[v].exp_rd_a});
            if (vecs[v].exp_rd > 1)
                check_output({tag, "rd_addr_b"}, {28'd0, get_rd(rd_base + 1)}, 32'd3);
            check_output({tag, "wr_count"}, wr_count - wr_base, vecs[v].exp_wr);
            if (vecs[v].exp_wr > 0) begin
                check_output({tag, "wr_addr"}, {28'd0, last_wr_addr}, {28'd0, vecs[v].exp_wr_addr});
                check_output({tag, "wr_data"}, {16'd0, last_wr_data}, {16'd0, vecs[v].exp_wr_data});
                check_output({tag, "wr_cycle"}, wr_cyc - c0, 32'd4);
            end
            @(posedge clk);
            @(negedge clk);
            check_output({tag, "back_to_idle"}, {30'd0, req_ready, resp_valid}, 32'b10);
        end

        // POP with the consumer stalling: the result must hold steady.
        regs[4]    = 16'h0300;
        resp_ready = 1'b0;
        apply_stimulus(3'd5, 16'h0000, lat);
        check_output("pop_hold_latency", lat, 32'd5);
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("pop_hold_%0d", i), {15'd0, resp_valid, resp_ea}, {15'd0, 1'b1, 16'h0300});
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("pop_hold_release", {30'd0, req_ready, resp_valid}, 32'b10);

        // PUSH aborted by reset while in CALC: the SP write must never appear.
        regs[4]   = 16'h0010;
        req_mode  = 3'd4;
        req_disp  = 16'h0000;
        req_valid = 1'b1;
        c0        = cyc;
        wr_base   = wr_count;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_output("calc_reset_no_write", wr_count - wr_base, 32'd0);
        check_output("calc_reset_idle", {30'd0, req_ready, resp_valid}, 32'b10);

        check_output("strobe_rules", bad_strobe, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
